three_port_ram: RTL and testbench



---
 rtl/three_port_ram_pkg.sv | 13 +
 rtl/three_port_ram_rd_port.sv | 20 ++
 rtl/three_port_ram.sv | 59 +++++
 tb/tb_three_port_ram.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/three_port_ram_pkg.sv
// Shared widths, typedefs and constants for the three-port register-file RAM.
package three_port_ram_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 8;

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    // Address of the hardwired-zero word.
    localparam int ZERO_REG = 0;

endpackage

// File: rtl/three_port_ram_rd_port.sv
// Combinational read mux for one port; word 0 always reads as zero.
module three_port_ram_rd_port #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH],
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data
);
    import three_port_ram_pkg::*;

    // Zero is forced here, so the word-0 storage cell is never observed.
    always_comb begin
        data = '0;
        if (addr != ADDR_WIDTH'(ZERO_REG)) begin
            data = mem[addr];
        end
    end

endmodule

// File: rtl/three_port_ram.sv
// 256x32 register file: two asynchronous read ports, one synchronous write port,
// word 0 hardwired to zero.
module three_port_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [ADDR_WIDTH-1:0] addr_wr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  we,
    output logic [DATA_WIDTH-1:0] data_a,
    output logic [DATA_WIDTH-1:0] data_b
);
    import three_port_ram_pkg::*;

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    // Reset wins over a same-edge write; writes to word 0 are dropped.
    always_comb begin
        mem_d = mem_q;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
        end else if (we && (addr_wr != ADDR_WIDTH'(ZERO_REG))) begin
            mem_d[addr_wr] = data_in;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Reads see mem_q only, so a same-address write shows up after the edge.
    three_port_ram_rd_port #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_rd_a (
        .mem  (mem_q),
        .addr (addr_a),
        .data (data_a)
    );

    three_port_ram_rd_port #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_rd_b (
        .mem  (mem_q),
        .addr (addr_b),
        .data (data_b)
    );

endmodule

// File: tb/tb_three_port_ram.sv
// Self-checking bench for three_port_ram against an array-based reference model.
module tb_three_port_ram;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int DEPTH = 256;

    logic          clk;
    logic          rst;
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;
    logic [AW-1:0] addr_wr;
    logic [DW-1:0] data_in;
    logic          we;
    logic [DW-1:0] data_a;
    logic [DW-1:0] data_b;

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q [$];

    int tests_run = 0;
    int fail_cnt  = 0;

    three_port_ram dut (
        .clk     (clk),
        .rst     (rst),
        .addr_a  (addr_a),
        .addr_b  (addr_b),
        .addr_wr (addr_wr),
        .data_in (data_in),
        .we      (we),
        .data_a  (data_a),
        .data_b  (data_b)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: word 0 reads zero, others hold last written value.
    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return (a == 0) ? '0 : ref_mem[a];
    endfunction

    // Model the effect of one clock edge with the current inputs.
    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        end else if (we && addr_wr != 0) begin
            ref_mem[addr_wr] = data_in;
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        we = 1'b1; addr_wr = a; data_in = d;
        tick();
        we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; we = 1'b1; addr_wr = 8'd9; data_in = $urandom;
        tick();
        rst = 1'b0; we = 1'b0;
        addr_a = 8'd5; addr_b = 8'd200;
        #1;
        tests_run++;
        if (data_a !== 32'h0) begin
            $display("FAIL reset_a: got %h want %h", data_a, 32'h0); fail_cnt++;
        end
        tests_run++;
        if (data_b !== 32'h0) begin
            $display("FAIL reset_b: got %h want %h", data_b, 32'h0); fail_cnt++;
        end
        for (int i = 0; i < DEPTH; i++) begin
            addr_a = AW'(i); addr_b = AW'(DEPTH - 1 - i);
            #1;
            tests_run++;
            if (data_a !== 32'h0 || data_b !== 32'h0) begin
                $display("FAIL reset_sweep[%0d]: got a=%h b=%h want 0", i, data_a, data_b);
                fail_cnt++;
            end
        end
    endtask

    task automatic test_basic();
        do_write(8'd1, 32'hA5A5A5A5);
        addr_a = 8'd1; addr_b = 8'd0;
        #1;
        tests_run++;
        if (data_a !== 32'hA5A5A5A5) begin
            $display("FAIL basic_a: got %h want %h", data_a, 32'hA5A5A5A5); fail_cnt++;
        end
        addr_b = 8'd1;
        #1;
        tests_run++;
        if (data_b !== 32'hA5A5A5A5) begin
            $display("FAIL basic_b: got %h want %h", data_b, 32'hA5A5A5A5); fail_cnt++;
        end
    endtask

    task automatic test_reg0();
        do_write(8'd0, 32'hFFFFFFFF);
        addr_a = 8'd0; addr_b = 8'd0;
        #1;
        tests_run++;
        if (data_a !== 32'h0 || data_b !== 32'h0) begin
            $display("FAIL reg0_read: got a=%h b=%h want 0", data_a, data_b); fail_cnt++;
        end
        addr_a = 8'd1;
        #1;
        tests_run++;
        if (data_a !== 32'hA5A5A5A5) begin
            $display("FAIL reg0_word1: got %h want %h", data_a, 32'hA5A5A5A5); fail_cnt++;
        end
    endtask

    task automatic test_read_during_write();
        do_write(8'd7, 32'h11111111);
        addr_a = 8'd7; addr_b = 8'd7;
        addr_wr = 8'd7; data_in = 32'h22222222; we = 1'b1;
        #1;
        tests_run++;
        if (data_a !== 32'h11111111 || data_b !== 32'h11111111) begin
            $display("FAIL rdw_before: got a=%h b=%h want %h", data_a, data_b, 32'h11111111);
            fail_cnt++;
        end
        tick();
        we = 1'b0;
        tests_run++;
        if (data_a !== 32'h22222222 || data_b !== 32'h22222222) begin
            $display("FAIL rdw_after: got a=%h b=%h want %h", data_a, data_b, 32'h22222222);
            fail_cnt++;
        end
    endtask

    task automatic test_ports();
        do_write(8'd255, 32'hDEADBEEF);
        do_write(8'd2, 32'h12345678);
        addr_a = 8'd255; addr_b = 8'd2;
        #1;
        tests_run++;
        if (data_a !== 32'hDEADBEEF || data_b !== 32'h12345678) begin
            $display("FAIL ports_direct: got a=%h b=%h want DEADBEEF 12345678", data_a, data_b);
            fail_cnt++;
        end
        addr_a = 8'd2; addr_b = 8'd255;
        #1;
        tests_run++;
        if (data_a !== 32'h12345678 || data_b !== 32'hDEADBEEF) begin
            $display("FAIL ports_swap: got a=%h b=%h want 12345678 DEADBEEF", data_a, data_b);
            fail_cnt++;
        end
    endtask

    task automatic test_reset_beats_write();
        do_write(8'd3, 32'hCAFEF00D);
        addr_a = 8'd3;
        #1;
        tests_run++;
        if (data_a !== 32'hCAFEF00D) begin
            $display("FAIL rbw_pre: got %h want %h", data_a, 32'hCAFEF00D); fail_cnt++;
        end
        rst = 1'b1; we = 1'b1; addr_wr = 8'd3; data_in = 32'h0BADBEEF;
        tick();
        rst = 1'b0; we = 1'b0;
        tests_run++;
        if (data_a !== 32'h0) begin
            $display("FAIL rbw_post: got %h want %h", data_a, 32'h0); fail_cnt++;
        end
    endtask

    // Random traffic: expected values are queued from the model, then compared.
    task automatic test_random();
        logic [DW-1:0] exp_v;
        for (int n = 0; n < 600; n++) begin
            we      = ($urandom_range(0, 3) != 0);
            addr_wr = ($urandom_range(0, 15) == 0) ? 8'd0 : AW'($urandom_range(0, DEPTH - 1));
            data_in = $urandom;
            addr_a  = ($urandom_range(0, 3) == 0) ? addr_wr : AW'($urandom_range(0, DEPTH - 1));
            addr_b  = ($urandom_range(0, 3) == 0) ? addr_a  : AW'($urandom_range(0, DEPTH - 1));
            #1;
            exp_q.push_back(ref_read(addr_a));
            exp_q.push_back(ref_read(addr_b));
            exp_v = exp_q.pop_front();
            tests_run++;
            if (data_a !== exp_v) begin
                $display("FAIL rand_pre_a[%0d]: addr %0d got %h want %h", n, addr_a, data_a, exp_v);
                fail_cnt++;
            end
            exp_v = exp_q.pop_front();
            tests_run++;
            if (data_b !== exp_v) begin
                $display("FAIL rand_pre_b[%0d]: addr %0d got %h want %h", n, addr_b, data_b, exp_v);
                fail_cnt++;
            end
            tick();
            exp_v = ref_read(addr_a);
            tests_run++;
            if (data_a !== exp_v) begin
                $display("FAIL rand_post_a[%0d]: addr %0d got %h want %h", n, addr_a, data_a, exp_v);
                fail_cnt++;
            end
            exp_v = ref_read(addr_b);
            tests_run++;
            if (data_b !== exp_v) begin
                $display("FAIL rand_post_b[%0d]: addr %0d got %h want %h", n, addr_b, data_b, exp_v);
                fail_cnt++;
            end
        end
        we = 1'b0;
    endtask

    initial begin
        rst = 1'b0; we = 1'b0;
        addr_a = '0; addr_b = '0; addr_wr = '0; data_in = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_reg0();
        test_read_during_write();
        test_ports();
        test_reset_beats_write();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
